// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The OVERFLOW_FLAG_EN macro adds the signed-overflow output.
package nsa_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

endpackage

// File: rtl/csa_nibble.sv
// Combinational 4-bit carry-select adder: both carry-in cases are
// rippled in parallel, then the real carry-in picks one.
module csa_nibble
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
`ifdef OVERFLOW_FLAG_EN
    output logic             c3,
`endif
    output logic             co
);

    logic [NIB_W:0]   c0;
    logic [NIB_W:0]   c1;
    logic [NIB_W-1:0] s0;
    logic [NIB_W-1:0] s1;

    always_comb begin
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int i = 0; i < NIB_W; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign s  = ci ? s1 : s0;
    assign co = ci ? c1[NIB_W] : c0[NIB_W];
`ifdef OVERFLOW_FLAG_EN
    assign c3 = ci ? c1[NIB_W-1] : c0[NIB_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one nibble per clock through a single
// carry-select stage. Define OVERFLOW_FLAG_EN for the ovf output.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [NIB_W-1:0] nib_s;
    logic             nib_co;
`ifdef OVERFLOW_FLAG_EN
    logic             nib_c3;
    logic             ovf_q, ovf_d;
`endif

    csa_nibble u_nib (
        .a  (a_q[NIB_W-1:0]),
        .b  (b_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (nib_s),
`ifdef OVERFLOW_FLAG_EN
        .c3 (nib_c3),
`endif
        .co (nib_co)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Result nibbles enter at the top and drift down to place.
                sum_d   = WIDTH'({nib_s, sum_q} >> NIB_W);
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                carry_d = nib_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d      = nib_co;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d       = nib_c3 ^ nib_co;
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed plus random check of nibble_serial_adder against a
// plain-arithmetic reference of a + b + cin.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
`ifdef OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // Issue one add, hold out_ready low for `hold` cycles in DONE.
    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c, input int hold, input string tag);
        logic [W:0] exp;
        int lat;
        exp = ref_add(x, y, c);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(NIB));
        chk({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(exp[W]));
`ifdef OVERFLOW_FLAG_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(sum), 32'(exp[W-1:0]));
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_back_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic rc;
        logic [W:0] e;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        run_add(16'h1234, 16'h4321, 1'b0, 0, "basic");
        run_add(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
        run_add(16'hFFFF, 16'h0000, 1'b1, 1, "cin_ripple");
        run_add(16'h0000, 16'h0000, 1'b0, 0, "zero");

        // Backpressure with a stray in_valid pulse while in DONE.
        e = ref_add(16'h00F0, 16'h0F10, 1'b0);
        @(negedge clk);
        a = 16'h00F0; b = 16'h0F10; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NIB) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
            @(negedge clk);
            chk("bp_sum", 32'(sum), 32'(e[W-1:0]));
            chk("bp_cout", 32'(cout), 32'(e[W]));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_drop_valid", 32'(out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        repeat (NIB + 2) @(negedge clk);
        chk("bp_stray_ignored", 32'(out_valid), 32'd0);

        // Reset in the middle of an add.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NIB + 2) @(negedge clk);
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        run_add(16'h0001, 16'h0001, 1'b0, 0, "after_rst");

        run_add(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        run_add(16'h8000, 16'h8000, 1'b0, 0, "ovf_neg");

        for (int n = 0; n < 12; n++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            run_add(rx, ry, rc, int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
